lmsm_sequencer: RTL and testbench
=================================

// Module: lmsm_sequencer
// PURPOSE
//  Decode-stage controller for LM/SM (load/store multiple) instructions. It holds the LM/SM word in PR2.
//  It walks the 8-bit register mask and issues one single-register transfer per cycle, with its memory offset, into the ID/RR datapath.
//  While it runs, it stalls PC/PR1/PR2 writes.
//  Transfers downstream look like ordinary LW/SW ops, so the forwarding and hazard logic needs no changes.
// PARAMETERS
//  OPC_LM   4'b0110  opcode of load-multiple (I[15:12])
//  OPC_SM   4'b0111  opcode of store-multiple (I[15:12])
// PORTS
//  clk           in   1   single clock, rising edge
//  rst           in   1   synchronous, active-high reset
//  I_PR2         in   16  instruction word held in IF/ID register
//  V_PR2         in   1   PR2 holds a valid (non-bubble) instruction
//  Stall_In      in   1   external stall (load-use etc.); freezes sequencer
//  Flush         in   1   branch/jump flush from EX/MEM; kills sequence
//  Seq_Busy      out  1   hold PC, PR1, PR2 write-enables low this cycle
//  Seq_Valid     out  1   a transfer is issued into PR3 this cycle
//  Seq_Load      out  1   1 = LM transfer (reg write), 0 = SM transfer
//  Seq_Reg       out  3   register index of the issued transfer
//  Seq_Base      out  3   base register RA (latched I[11:9])
//  Seq_Offset    out  3   word offset added to RA for this transfer
//  Seq_Last      out  1   issued transfer is the final one of the sequence
//  Seq_Xfer_Cnt  out  16  issued-transfer count (only with LMSM_PERF_CNT_EN)
// BEHAVIOUR
//  - States: IDLE, RUN. Regs: Mask_R[7:0], Off_R[2:0], Base_R[2:0], Load_R.
//  - Mask bit k selects Rk. Issue order is ascending k. Offsets are 0,1,2,... in issue order, independent of k.
//  - Start = IDLE & V_PR2 & !Stall_In & !Flush & (I_PR2[15:12]==OPC_LM | OPC_SM).
//  - Start with I_PR2[7:0]!=0:
//    - Seq_Busy=1 that cycle (comb).
//    - Latch Mask_R=I[7:0], Base_R=I[11:9], Load_R=(opc==OPC_LM), Off_R=0.
//    - Next state RUN. First transfer is issued one cycle after Start.
//  - Start with mask==0: treated as NOP. No Busy, no Valid, stay IDLE, PR2 advances normally.
//  - RUN & !Stall_In & !Flush: issue one transfer.
//    - Seq_Valid=1, Seq_Reg=lowest set bit of Mask_R, Seq_Offset=Off_R.
//    - Seq_Last=(popcount(Mask_R)==1).
//    - Next cycle: clear that mask bit, Off_R+1.
//  - Seq_Busy in RUN = !(issuing & Seq_Last). On the last issue, PR2 is released in the same cycle; next state is IDLE.
//  - RUN & Stall_In: all regs hold, Seq_Valid=0, Seq_Busy=1, no offset advance.
//  - Flush (any state): highest priority. Seq_Valid=0 and Seq_Busy=0 that cycle; next state IDLE, Mask_R=0.
//  - Flush and Stall_In together: Flush wins.
//  - Start is not evaluated while in RUN. IDLE may accept a new LM/SM in the cycle right after a last issue (back-to-back).
//  - Off_R is 3 bits and cannot wrap: at most 8 transfers.
//  - Seq_Load, Seq_Base, Seq_Reg, Seq_Offset are driven from regs/comb and valid only when Seq_Valid=1; they are 0 in IDLE.
//  - rst (sync, also mid-RUN):
//    - state=IDLE, all regs 0.
//    - Seq_Busy, Seq_Valid, Seq_Last, Seq_Load=0; Seq_Reg, Seq_Base, Seq_Offset=0.
//    - Seq_Xfer_Cnt=0.
// CONFIGURATION
//  LMSM_PERF_CNT_EN defined:
//   - Port Seq_Xfer_Cnt and a 16-bit counter exist.
//   - Counter increments on every cycle with Seq_Valid=1 and wraps 16'hFFFF -> 0.
//   - Only rst clears it; Flush does not.
//  LMSM_PERF_CNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1. LM, RA=3, mask 8'hA5:
//     - Busy on Start; then 4 RUN cycles issue Reg 0,2,5,7, Offset 0..3, Base 3, Load 1.
//     - Last and Busy=0 on 4th; IDLE after.
//  2. SM mask 8'hFF, Stall_In high on 3rd RUN cycle:
//     - One Valid=0 bubble; 8 transfers Reg 0..7, Offset 0..7 contiguous.
//     - Load 0; 9 RUN cycles total.
//  3. LM mask 8'h00: no Busy, no Valid, state stays IDLE.
//  4. LM mask 8'h0F, Flush on 2nd RUN cycle: only R0 issued, Valid=0 and Busy=0 on flush cycle, IDLE next.
//  5. SM mask 8'h81, rst on 1st RUN cycle: next cycle all outputs 0, IDLE; no R7 issued.
//  6. Back-to-back LM 8'h03 then SM 8'h10: 2 transfers, Start of SM in the cycle after Last, then 1 transfer.
//     With LMSM_PERF_CNT_EN, Seq_Xfer_Cnt ends at 3; preload-style run to 16'hFFFF + 1 wraps to 0.

Source files
------------

// File: rtl/lmsm_sequencer.sv
// LM/SM decode-stage sequencer: expands one load/store-multiple word into single-register transfers.
// Optional macro LMSM_PERF_CNT_EN adds the Seq_Xfer_Cnt issued-transfer counter port.
module lmsm_sequencer #(
  parameter logic [3:0] OPC_LM = 4'b0110,
  parameter logic [3:0] OPC_SM = 4'b0111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] I_PR2,
  input  logic        V_PR2,
  input  logic        Stall_In,
  input  logic        Flush,
  output logic        Seq_Busy,
  output logic        Seq_Valid,
  output logic        Seq_Load,
  output logic [2:0]  Seq_Reg,
  output logic [2:0]  Seq_Base,
  output logic [2:0]  Seq_Offset,
  output logic        Seq_Last
`ifdef LMSM_PERF_CNT_EN
  ,
  output logic [15:0] Seq_Xfer_Cnt
`endif
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  mask_q, mask_d;
  logic [2:0]  off_q, off_d;
  logic [2:0]  base_q, base_d;
  logic        load_q, load_d;

  logic [3:0]  opc;
  logic        is_lmsm;
  logic        start;
  logic [7:0]  below_any;
  logic [7:0]  low_onehot;
  logic [2:0]  low_idx;
  logic        single_bit;
  logic        unused_bit;

  assign opc        = I_PR2[15:12];
  assign is_lmsm    = (opc == OPC_LM) || (opc == OPC_SM);
  assign start      = (state_q == S_IDLE) && V_PR2 && !Stall_In && !Flush && is_lmsm;
  assign unused_bit = I_PR2[8];

  // Ripple "any lower bit set" chain isolates the lowest set mask bit.
  assign below_any[0] = 1'b0;
  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_below
      assign below_any[gi] = below_any[gi-1] | mask_q[gi-1];
    end
    for (gi = 0; gi < 8; gi++) begin : g_low
      assign low_onehot[gi] = mask_q[gi] & ~below_any[gi];
    end
  endgenerate

  always_comb begin
    low_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (low_onehot[k]) low_idx = low_idx | 3'(k);
    end
  end

  assign single_bit = (mask_q != 8'd0) && ((mask_q & (mask_q - 8'd1)) == 8'd0);

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    off_d      = off_q;
    base_d     = base_q;
    load_d     = load_q;
    Seq_Busy   = 1'b0;
    Seq_Valid  = 1'b0;
    Seq_Load   = 1'b0;
    Seq_Reg    = 3'd0;
    Seq_Base   = 3'd0;
    Seq_Offset = 3'd0;
    Seq_Last   = 1'b0;
    // Outputs are forced quiet while reset is asserted so nothing leaks downstream.
    if (!rst) begin
      if (Flush) begin
        state_d = S_IDLE;
        mask_d  = 8'd0;
      end
      case (state_q)
        S_IDLE: begin
          if (start && (I_PR2[7:0] != 8'd0)) begin
            Seq_Busy = 1'b1;
            mask_d   = I_PR2[7:0];
            base_d   = I_PR2[11:9];
            load_d   = (opc == OPC_LM);
            off_d    = 3'd0;
            state_d  = S_RUN;
          end
        end
        S_RUN: begin
          Seq_Load   = load_q;
          Seq_Base   = base_q;
          Seq_Reg    = low_idx;
          Seq_Offset = off_q;
          if (Flush) begin
            Seq_Busy = 1'b0;
          end else if (Stall_In) begin
            Seq_Busy = 1'b1;
          end else begin
            // Releasing PR2 on the final issue lets the next instruction start next cycle.
            Seq_Valid = 1'b1;
            Seq_Last  = single_bit;
            Seq_Busy  = !single_bit;
            mask_d    = mask_q & ~low_onehot;
            off_d     = off_q + 3'd1;
            if (single_bit) state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q  <= 8'd0;
      off_q   <= 3'd0;
      base_q  <= 3'd0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      off_q   <= off_d;
      base_q  <= base_d;
      load_q  <= load_d;
    end
  end

`ifdef LMSM_PERF_CNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  // Wraps naturally at 16 bits; Flush intentionally leaves the count alone.
  always_comb begin
    xfer_cnt_d = xfer_cnt_q + {15'd0, Seq_Valid};
  end

  always_ff @(posedge clk) begin
    if (rst) xfer_cnt_q <= 16'd0;
    else     xfer_cnt_q <= xfer_cnt_d;
  end

  assign Seq_Xfer_Cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer; counter checks are active when LMSM_PERF_CNT_EN is defined.
module tb_lmsm_sequencer;

  logic        clk = 1'b0;
  logic        rst, V_PR2, Stall_In, Flush;
  logic [15:0] I_PR2;
  logic        Seq_Busy, Seq_Valid, Seq_Load, Seq_Last;
  logic [2:0]  Seq_Reg, Seq_Base, Seq_Offset;
`ifdef LMSM_PERF_CNT_EN
  logic [15:0] Seq_Xfer_Cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lmsm_sequencer dut (
    .clk(clk), .rst(rst), .I_PR2(I_PR2), .V_PR2(V_PR2),
    .Stall_In(Stall_In), .Flush(Flush),
    .Seq_Busy(Seq_Busy), .Seq_Valid(Seq_Valid), .Seq_Load(Seq_Load),
    .Seq_Reg(Seq_Reg), .Seq_Base(Seq_Base), .Seq_Offset(Seq_Offset),
    .Seq_Last(Seq_Last)
`ifdef LMSM_PERF_CNT_EN
    , .Seq_Xfer_Cnt(Seq_Xfer_Cnt)
`endif
  );

  // Packed view: {Busy, Valid, Load, Reg, Base, Offset, Last}
  function automatic logic [12:0] e(input logic b, input logic v, input logic ld,
                                    input logic [2:0] r, input logic [2:0] ba,
                                    input logic [2:0] o, input logic l);
    return {b, v, ld, r, ba, o, l};
  endfunction

  // Checks the current cycle at the falling edge, then steps to just after the next rising edge.
  task automatic chk(input string tag, input logic [12:0] exp, input logic [12:0] care = 13'h1FFF);
    logic [12:0] obs;
    @(negedge clk);
    obs = {Seq_Busy, Seq_Valid, Seq_Load, Seq_Reg, Seq_Base, Seq_Offset, Seq_Last};
    n_cmp++;
    assert ((obs & care) === (exp & care)) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (care %h)", tag, obs, exp, care);
    end
    $display("step %-12s busy=%0b valid=%0b load=%0b reg=%0d base=%0d off=%0d last=%0b",
             tag, Seq_Busy, Seq_Valid, Seq_Load, Seq_Reg, Seq_Base, Seq_Offset, Seq_Last);
    @(posedge clk);
    #1;
  endtask

`ifdef LMSM_PERF_CNT_EN
  task automatic chk_cnt(input string tag, input logic [15:0] exp);
    n_cmp++;
    assert (Seq_Xfer_Cnt === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, Seq_Xfer_Cnt, exp);
    end
    $display("cnt  %-12s count=%h", tag, Seq_Xfer_Cnt);
  endtask
`endif

  localparam logic [12:0] CARE_BVL = 13'b1_1000_0000_0001;
  localparam logic [12:0] CARE_BV  = 13'b1_1000_0000_0000;

  initial begin
    rst = 1'b1; V_PR2 = 1'b0; Stall_In = 1'b0; Flush = 1'b0; I_PR2 = 16'h0000;
    @(posedge clk); #1;
    chk("reset", 13'd0);
    rst = 1'b0;
    chk("idle", 13'd0);

    // LM RA=3 mask A5
    V_PR2 = 1'b1; I_PR2 = 16'h66A5;
    chk("t1_start", e(1, 0, 0, 0, 0, 0, 0));
    chk("t1_r0",    e(1, 1, 1, 0, 3, 0, 0));
    chk("t1_r2",    e(1, 1, 1, 2, 3, 1, 0));
    chk("t1_r5",    e(1, 1, 1, 5, 3, 2, 0));
    chk("t1_r7",    e(0, 1, 1, 7, 3, 3, 1));
    V_PR2 = 1'b0;
    chk("t1_idle", 13'd0);

    // SM RA=5 mask FF with a stall on the third RUN cycle
    V_PR2 = 1'b1; I_PR2 = 16'h7AFF;
    chk("t2_start", e(1, 0, 0, 0, 0, 0, 0));
    chk("t2_r0",    e(1, 1, 0, 0, 5, 0, 0));
    chk("t2_r1",    e(1, 1, 0, 1, 5, 1, 0));
    Stall_In = 1'b1;
    chk("t2_stall", e(1, 0, 0, 0, 0, 0, 0), CARE_BVL);
    Stall_In = 1'b0;
    for (int k = 2; k < 8; k++) begin
      chk($sformatf("t2_r%0d", k), e(k != 7, 1, 0, 3'(k), 5, 3'(k), k == 7));
    end
    V_PR2 = 1'b0;
    chk("t2_idle", 13'd0);

    // LM with empty mask is a NOP
    V_PR2 = 1'b1; I_PR2 = 16'h6200;
    chk("t3_nop",  13'd0);
    chk("t3_nop2", 13'd0);
    V_PR2 = 1'b0;
    chk("t3_idle", 13'd0);

    // LM RA=2 mask 0F, flush on second RUN cycle
    V_PR2 = 1'b1; I_PR2 = 16'h640F;
    chk("t4_start", e(1, 0, 0, 0, 0, 0, 0));
    chk("t4_r0",    e(1, 1, 1, 0, 2, 0, 0));
    Flush = 1'b1;
    chk("t4_flush", e(0, 0, 0, 0, 0, 0, 0), CARE_BV);
    Flush = 1'b0; V_PR2 = 1'b0;
    chk("t4_idle",  13'd0);
    chk("t4_idle2", 13'd0);

    // SM RA=7 mask 81, reset on first RUN cycle
    V_PR2 = 1'b1; I_PR2 = 16'h7E81;
    chk("t5_start", e(1, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    chk("t5_rst", 13'd0);
    rst = 1'b0; V_PR2 = 1'b0;
    chk("t5_after",  13'd0);
    chk("t5_after2", 13'd0);

    // Back-to-back LM 03 then SM 10, from a fresh reset
    rst = 1'b1;
    chk("t6_reset", 13'd0);
    rst = 1'b0;
`ifdef LMSM_PERF_CNT_EN
    chk_cnt("t6_cnt0", 16'd0);
`endif
    V_PR2 = 1'b1; I_PR2 = 16'h6003;
    chk("t6_lm_start", e(1, 0, 0, 0, 0, 0, 0));
    chk("t6_lm_r0",    e(1, 1, 1, 0, 0, 0, 0));
    chk("t6_lm_r1",    e(0, 1, 1, 1, 0, 1, 1));
    I_PR2 = 16'h7810;
    chk("t6_sm_start", e(1, 0, 0, 0, 0, 0, 0));
    chk("t6_sm_r4",    e(0, 1, 0, 4, 4, 0, 1));
    V_PR2 = 1'b0;
    chk("t6_idle", 13'd0);
`ifdef LMSM_PERF_CNT_EN
    chk_cnt("t6_cnt3", 16'd3);

    // Preload the counter to its top value and confirm wraparound
    @(negedge clk);
    force dut.xfer_cnt_q = 16'hFFFF;
    #1;
    release dut.xfer_cnt_q;
    @(posedge clk); #1;
    chk_cnt("wrap_pre", 16'hFFFF);
    V_PR2 = 1'b1; I_PR2 = 16'h7001;
    chk("wrap_start", e(1, 0, 0, 0, 0, 0, 0));
    chk("wrap_r0",    e(0, 1, 0, 0, 0, 0, 1));
    V_PR2 = 1'b0;
    chk_cnt("wrap_post", 16'h0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
